// File: rtl/multicycle_main_control_if.sv
// Control bundle between the multicycle main control FSM and the MIPS datapath.
// The controller (master) receives the opcode and memory handshake and drives
// every datapath select/enable plus its debug and retirement outputs.
interface multicycle_main_control_if #(
   parameter int COUNT_WIDTH = 32
);
   logic [5:0]             opcode;
   logic                   mem_ready;
   logic                   pc_write;
   logic                   pc_write_cond;
   logic [1:0]             pc_source;
   logic                   i_or_d;
   logic                   mem_read;
   logic                   mem_write;
   logic                   ir_write;
   logic                   mem_to_reg;
   logic                   reg_dst;
   logic                   reg_write;
   logic                   alu_src_a;
   logic [1:0]             alu_src_b;
   logic [1:0]             alu_op;
   logic                   illegal_op;
   logic [3:0]             state;
   logic [COUNT_WIDTH-1:0] instr_count;

   modport master (
      input  opcode, mem_ready,
      output pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
             ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b,
             alu_op, illegal_op, state, instr_count
   );

   modport slave (
      output opcode, mem_ready,
      input  pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
             ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b,
             alu_op, illegal_op, state, instr_count
   );
endinterface

// File: rtl/multicycle_main_control.sv
// Main control FSM of the multicycle MIPS datapath: sequences fetch, decode,
// execute, memory and writeback, stalls on mem_ready and counts retirements.
// Control outputs are Moore-decoded from the state register; only the FETCH
// write enables follow mem_ready and illegal_op follows the DECODE opcode.
module multicycle_main_control #(
   parameter int COUNT_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   multicycle_main_control_if.master bus
);

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_ADDI = 6'b001000;

   typedef enum logic [3:0] {
      S_FETCH     = 4'd0,
      S_DECODE    = 4'd1,
      S_MEM_ADDR  = 4'd2,
      S_MEM_READ  = 4'd3,
      S_MEM_WB    = 4'd4,
      S_MEM_WRITE = 4'd5,
      S_EXECUTE   = 4'd6,
      S_R_WB      = 4'd7,
      S_BRANCH    = 4'd8,
      S_JUMP      = 4'd9,
      S_ADDI_EX   = 4'd10,
      S_ADDI_WB   = 4'd11
   } state_t;

   state_t                 state_reg;
   logic [5:0]             op_q;
   logic [COUNT_WIDTH-1:0] count_reg;

   // State sequencing, opcode capture in DECODE and retirement counting.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= S_FETCH;
         op_q      <= '0;
         count_reg <= '0;
      end else begin
         case (state_reg)
            S_FETCH: begin
               if (bus.mem_ready) state_reg <= S_DECODE;
            end
            S_DECODE: begin
               op_q <= bus.opcode;
               case (bus.opcode)
                  OP_LW, OP_SW: state_reg <= S_MEM_ADDR;
                  OP_R:         state_reg <= S_EXECUTE;
                  OP_BEQ:       state_reg <= S_BRANCH;
                  OP_J:         state_reg <= S_JUMP;
                  OP_ADDI:      state_reg <= S_ADDI_EX;
                  default:      state_reg <= S_FETCH;  // illegal: not retired
               endcase
            end
            S_MEM_ADDR: begin
               if (op_q == OP_LW)      state_reg <= S_MEM_READ;
               else if (op_q == OP_SW) state_reg <= S_MEM_WRITE;
               else                    state_reg <= S_FETCH;
            end
            S_MEM_READ: begin
               if (bus.mem_ready) state_reg <= S_MEM_WB;
            end
            S_MEM_WRITE: begin
               if (bus.mem_ready) begin
                  state_reg <= S_FETCH;
                  count_reg <= count_reg + 1'b1;
               end
            end
            S_EXECUTE: state_reg <= S_R_WB;
            S_ADDI_EX: state_reg <= S_ADDI_WB;
            S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_ADDI_WB: begin
               state_reg <= S_FETCH;
               count_reg <= count_reg + 1'b1;
            end
            default: state_reg <= S_FETCH;
         endcase
      end
   end

   // Control decode from the current state; everything is 0 during reset.
   always_comb begin
      bus.pc_write      = 1'b0;
      bus.pc_write_cond = 1'b0;
      bus.pc_source     = 2'b00;
      bus.i_or_d        = 1'b0;
      bus.mem_read      = 1'b0;
      bus.mem_write     = 1'b0;
      bus.ir_write      = 1'b0;
      bus.mem_to_reg    = 1'b0;
      bus.reg_dst       = 1'b0;
      bus.reg_write     = 1'b0;
      bus.alu_src_a     = 1'b0;
      bus.alu_src_b     = 2'b00;
      bus.alu_op        = 2'b00;
      bus.illegal_op    = 1'b0;
      if (!rst) begin
         case (state_reg)
            S_FETCH: begin
               bus.mem_read  = 1'b1;
               bus.alu_src_b = 2'b01;
               bus.ir_write  = bus.mem_ready;
               bus.pc_write  = bus.mem_ready;
            end
            S_DECODE: begin
               bus.alu_src_b = 2'b11;
               case (bus.opcode)
                  OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: bus.illegal_op = 1'b0;
                  default:                                   bus.illegal_op = 1'b1;
               endcase
            end
            S_MEM_ADDR, S_ADDI_EX: begin
               bus.alu_src_a = 1'b1;
               bus.alu_src_b = 2'b10;
            end
            S_MEM_READ: begin
               bus.mem_read = 1'b1;
               bus.i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
               bus.reg_write  = 1'b1;
               bus.mem_to_reg = 1'b1;
            end
            S_MEM_WRITE: begin
               bus.mem_write = 1'b1;
               bus.i_or_d    = 1'b1;
            end
            S_EXECUTE: begin
               bus.alu_src_a = 1'b1;
               bus.alu_op    = 2'b10;
            end
            S_R_WB: begin
               bus.reg_write = 1'b1;
               bus.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
               bus.alu_src_a     = 1'b1;
               bus.alu_op        = 2'b01;
               bus.pc_write_cond = 1'b1;
               bus.pc_source     = 2'b01;
            end
            S_JUMP: begin
               bus.pc_write  = 1'b1;
               bus.pc_source = 2'b10;
            end
            S_ADDI_WB: begin
               bus.reg_write = 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.state       = state_reg;
   assign bus.instr_count = count_reg;

endmodule

// File: tb/tb_multicycle_main_control.sv
// Directed bench for multicycle_main_control (COUNT_WIDTH=4 so wrap is reachable).
module tb_multicycle_main_control;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_BAD  = 6'b111111;

   // {pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write, ir_write,
   //  mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, illegal_op}
   localparam logic [16:0] C_ZERO    = 17'b0_0_00_0_0_0_0_0_0_0_0_00_00_0;
   localparam logic [16:0] C_FETCH   = 17'b1_0_00_0_1_0_1_0_0_0_0_01_00_0;
   localparam logic [16:0] C_FSTALL  = 17'b0_0_00_0_1_0_0_0_0_0_0_01_00_0;
   localparam logic [16:0] C_DEC     = 17'b0_0_00_0_0_0_0_0_0_0_0_11_00_0;
   localparam logic [16:0] C_DEC_ILL = 17'b0_0_00_0_0_0_0_0_0_0_0_11_00_1;
   localparam logic [16:0] C_ADDR    = 17'b0_0_00_0_0_0_0_0_0_0_1_10_00_0;
   localparam logic [16:0] C_MREAD   = 17'b0_0_00_1_1_0_0_0_0_0_0_00_00_0;
   localparam logic [16:0] C_MWB     = 17'b0_0_00_0_0_0_0_1_0_1_0_00_00_0;
   localparam logic [16:0] C_MWRITE  = 17'b0_0_00_1_0_1_0_0_0_0_0_00_00_0;
   localparam logic [16:0] C_EXE     = 17'b0_0_00_0_0_0_0_0_0_0_1_00_10_0;
   localparam logic [16:0] C_RWB     = 17'b0_0_00_0_0_0_0_0_1_1_0_00_00_0;
   localparam logic [16:0] C_BRANCH  = 17'b0_1_01_0_0_0_0_0_0_0_1_00_01_0;
   localparam logic [16:0] C_JUMP    = 17'b1_0_10_0_0_0_0_0_0_0_0_00_00_0;
   localparam logic [16:0] C_AWB     = 17'b0_0_00_0_0_0_0_0_0_1_0_00_00_0;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   tests = 0;
   int   fails = 0;

   multicycle_main_control_if #(.COUNT_WIDTH(4)) bus ();

   multicycle_main_control #(.COUNT_WIDTH(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   logic [16:0] ctl;
   assign ctl = {bus.pc_write, bus.pc_write_cond, bus.pc_source, bus.i_or_d,
                 bus.mem_read, bus.mem_write, bus.ir_write, bus.mem_to_reg,
                 bus.reg_dst, bus.reg_write, bus.alu_src_a, bus.alu_src_b,
                 bus.alu_op, bus.illegal_op};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      tests++;
      assert (obs === expv)
      else begin
         fails++;
         $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
      end
   endtask

   // Drive inputs, check state/controls/count for this cycle, then clock once.
   task automatic step(input string tag, input logic [5:0] op, input logic mr,
                       input logic [3:0] es, input logic [16:0] ec, input int en);
      bus.opcode    = op;
      bus.mem_ready = mr;
      #1;
      $display("[TB] %-12s op=%b mr=%b state=%0d ctl=%b count=%0d",
               tag, op, mr, bus.state, ctl, bus.instr_count);
      check({tag, ".state"}, 32'(bus.state), 32'(es));
      check({tag, ".ctl"},   32'(ctl),       32'(ec));
      check({tag, ".count"}, 32'(bus.instr_count), 32'(en[3:0]));
      @(posedge clk);
      #1;
   endtask

   initial begin
      bus.opcode    = OP_R;
      bus.mem_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_gate_fetch", 32'(ctl), 32'(C_ZERO));
      rst = 1'b0;

      // Reach EXECUTE, then reset there for two cycles.
      step("pre_fetch",  OP_R, 1'b1, 4'd0, C_FETCH, 0);
      step("pre_dec",    OP_R, 1'b1, 4'd1, C_DEC,   0);
      rst = 1'b1;
      #1;
      check("rst_in_s6.state", 32'(bus.state), 32'd6);
      check("rst_in_s6.ctl",   32'(ctl),       32'(C_ZERO));
      @(posedge clk);
      #1;
      check("rst_cyc2.state", 32'(bus.state), 32'd0);
      check("rst_cyc2.ctl",   32'(ctl),       32'(C_ZERO));
      @(posedge clk);
      #1;
      rst = 1'b0;

      // R-type
      step("r_fetch", OP_R, 1'b1, 4'd0, C_FETCH, 0);
      step("r_dec",   OP_R, 1'b1, 4'd1, C_DEC,   0);
      step("r_exe",   OP_R, 1'b1, 4'd6, C_EXE,   0);
      step("r_wb",    OP_R, 1'b1, 4'd7, C_RWB,   0);

      // lw with three wait cycles in MEM_READ
      step("lw_fetch", OP_LW, 1'b1, 4'd0, C_FETCH, 1);
      step("lw_dec",   OP_LW, 1'b1, 4'd1, C_DEC,   1);
      step("lw_addr",  OP_LW, 1'b1, 4'd2, C_ADDR,  1);
      step("lw_rd_w1", OP_LW, 1'b0, 4'd3, C_MREAD, 1);
      step("lw_rd_w2", OP_LW, 1'b0, 4'd3, C_MREAD, 1);
      step("lw_rd_w3", OP_LW, 1'b0, 4'd3, C_MREAD, 1);
      step("lw_rd",    OP_LW, 1'b1, 4'd3, C_MREAD, 1);
      step("lw_wb",    OP_LW, 1'b0, 4'd4, C_MWB,   1);

      // beq then j
      step("beq_fetch", OP_BEQ, 1'b1, 4'd0, C_FETCH,  2);
      step("beq_dec",   OP_BEQ, 1'b1, 4'd1, C_DEC,    2);
      step("beq_br",    OP_BEQ, 1'b0, 4'd8, C_BRANCH, 2);
      step("j_fetch",   OP_J,   1'b1, 4'd0, C_FETCH,  3);
      step("j_dec",     OP_J,   1'b1, 4'd1, C_DEC,    3);
      step("j_jump",    OP_J,   1'b0, 4'd9, C_JUMP,   3);

      // Illegal opcode: one DECODE cycle flagged, no retirement
      step("ill_fetch", OP_BAD, 1'b1, 4'd0, C_FETCH,   4);
      step("ill_dec",   OP_BAD, 1'b1, 4'd1, C_DEC_ILL, 4);

      // sw with opcode changed to lw after DECODE: must still write
      step("sw_fetch",  OP_SW, 1'b1, 4'd0, C_FETCH,  4);
      step("sw_dec",    OP_SW, 1'b1, 4'd1, C_DEC,    4);
      step("sw_addr",   OP_LW, 1'b1, 4'd2, C_ADDR,   4);
      step("sw_wr_w1",  OP_LW, 1'b0, 4'd5, C_MWRITE, 4);
      step("sw_wr",     OP_LW, 1'b1, 4'd5, C_MWRITE, 4);
      step("sw_done",   OP_LW, 1'b0, 4'd0, C_FSTALL, 5);

      // Fresh count, stall FETCH, then 17 addi to wrap the 4-bit counter
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      step("f_stall1", OP_ADDI, 1'b0, 4'd0, C_FSTALL, 0);
      step("f_stall2", OP_ADDI, 1'b0, 4'd0, C_FSTALL, 0);
      for (int k = 0; k < 17; k++) begin
         step("addi_fetch", OP_ADDI, 1'b1, 4'd0,  C_FETCH, k % 16);
         step("addi_dec",   OP_ADDI, 1'b1, 4'd1,  C_DEC,   k % 16);
         step("addi_ex",    OP_ADDI, 1'b1, 4'd10, C_ADDR,  k % 16);
         step("addi_wb",    OP_ADDI, 1'b1, 4'd11, C_AWB,   k % 16);
      end
      step("wrap_fetch", OP_ADDI, 1'b0, 4'd0, C_FSTALL, 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
